// File: rtl/filt_cic_comp.sv
// CIC droop compensator: symmetric 7-tap FIR evaluated serially on a single
// multiplier, one output per accepted decimated sample.
module filt_cic_comp #(
    parameter int gp_inp_width  = 16,
    parameter int gp_oup_width  = 16,
    parameter int gp_coef_width = 12,
    parameter int gp_coef_frac  = 10,
    parameter int gp_c0         = -24,
    parameter int gp_c1         = 60,
    parameter int gp_c2         = -140,
    parameter int gp_c3         = 1232
) (
    input  logic                    i_clk,
    input  logic                    i_rst_an,
    input  logic                    i_ena,
    input  logic                    i_valid,
    input  logic [gp_inp_width-1:0] i_data,
    output logic [gp_oup_width-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic                    o_overrun
);
    localparam int ACC_W  = gp_inp_width + gp_coef_width + 3;
    localparam int PROD_W = gp_inp_width + gp_coef_width;
    localparam int RND_W  = ACC_W + 1;
    localparam int SH_W   = RND_W - gp_coef_frac;

    localparam logic signed [gp_coef_width-1:0] C0 = gp_coef_width'(gp_c0);
    localparam logic signed [gp_coef_width-1:0] C1 = gp_coef_width'(gp_c1);
    localparam logic signed [gp_coef_width-1:0] C2 = gp_coef_width'(gp_c2);
    localparam logic signed [gp_coef_width-1:0] C3 = gp_coef_width'(gp_c3);
    localparam logic signed [RND_W-1:0] HALF = RND_W'(2 ** (gp_coef_frac - 1));
    localparam logic signed [SH_W-1:0] SMAX = SH_W'((2 ** (gp_oup_width - 1)) - 1);
    localparam logic signed [SH_W-1:0] SMIN = SH_W'(-(2 ** (gp_oup_width - 1)));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic                            accept;
    logic signed [gp_inp_width-1:0]  x [0:6];
    logic signed [ACC_W-1:0]         acc;
    logic [2:0]                      tap;
    logic signed [gp_coef_width-1:0] coef;
    logic signed [gp_inp_width-1:0]  samp;
    logic signed [PROD_W-1:0]        prod;
    logic signed [RND_W-1:0]         rnd;
    logic signed [SH_W-1:0]          shr;
    logic signed [gp_oup_width-1:0]  sat;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (i_ena) begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        accept    = 1'b1;
                        state_nxt = MAC;
                    end
                end
                MAC: begin
                    if (tap == 3'd6) begin
                        state_nxt = OUT;
                    end
                end
                OUT: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Kernel is symmetric, so taps k and 6-k share a coefficient.
    always_comb begin
        coef = C3;
        samp = x[3];
        unique case (tap)
            3'd0: begin coef = C0; samp = x[0]; end
            3'd1: begin coef = C1; samp = x[1]; end
            3'd2: begin coef = C2; samp = x[2]; end
            3'd4: begin coef = C2; samp = x[4]; end
            3'd5: begin coef = C1; samp = x[5]; end
            3'd6: begin coef = C0; samp = x[6]; end
            default: begin coef = C3; samp = x[3]; end
        endcase
    end

    assign prod = coef * samp;

    always_comb begin
        rnd = RND_W'(acc) + HALF;
        shr = SH_W'(rnd >>> gp_coef_frac);
        if (shr > SMAX) begin
            sat = gp_oup_width'(SMAX);
        end else if (shr < SMIN) begin
            sat = gp_oup_width'(SMIN);
        end else begin
            sat = gp_oup_width'(shr);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 0; i < 7; i++) begin
                x[i] <= '0;
            end
            acc       <= '0;
            tap       <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_ena) begin
                if (i_valid && state != IDLE) begin
                    o_overrun <= 1'b1;
                end
                if (accept) begin
                    x[0] <= i_data;
                    for (int i = 1; i < 7; i++) begin
                        x[i] <= x[i-1];
                    end
                    acc <= '0;
                    tap <= '0;
                end
                if (state == MAC) begin
                    acc <= acc + ACC_W'(prod);
                    tap <= (tap == 3'd6) ? 3'd0 : tap + 3'd1;
                end
                if (state == OUT) begin
                    o_data  <= sat;
                    o_valid <= 1'b1;
                end
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_filt_cic_comp.sv
// Directed bench for filt_cic_comp: per-cycle comparison against a
// transaction-level model plus literal output sequences.
module tb_filt_cic_comp;
    logic        i_clk = 1'b0;
    logic        i_rst_an;
    logic        i_ena;
    logic        i_valid;
    logic [15:0] i_data;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outq[$];
    int vcyc[$];

    int h[7] = '{-24, 60, -140, 1232, -140, 60, -24};
    int hist[7];
    int busy_cnt;
    int pending;
    int m_data;
    int m_valid;
    int m_ovr;

    filt_cic_comp dut (
        .i_clk(i_clk),
        .i_rst_an(i_rst_an),
        .i_ena(i_ena),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_busy(o_busy),
        .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int model_out();
        longint s;
        longint q;
        s = 0;
        for (int k = 0; k < 7; k++) begin
            s += longint'(h[k]) * longint'(hist[k]);
        end
        s += 512;
        if (s >= 0) q = s / 1024;
        else q = -((-s + 1023) / 1024);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 7; k++) hist[k] = 0;
        busy_cnt = 0;
        pending = 0;
        m_data = 0;
        m_valid = 0;
        m_ovr = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk);
            cyc++;
            if (!i_rst_an) begin
                model_reset();
            end else begin
                m_valid = 0;
                if (i_ena) begin
                    if (busy_cnt > 0) begin
                        if (i_valid) m_ovr = 1;
                        busy_cnt--;
                        if (busy_cnt == 0) begin
                            m_valid = 1;
                            m_data = pending;
                        end
                    end else if (i_valid) begin
                        for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
                        hist[0] = int'($signed(i_data));
                        pending = model_out();
                        busy_cnt = 8;
                    end
                end
            end
            #1;
            if (!i_rst_an) model_reset();
            if (o_valid) begin
                outq.push_back(int'($signed(o_data)));
                vcyc.push_back(cyc);
            end
            check("o_valid", int'(o_valid), m_valid);
            check("o_busy", int'(o_busy), int'(busy_cnt != 0));
            check("o_overrun", int'(o_overrun), m_ovr);
            check("o_data", int'($signed(o_data)), m_data);
        end
    end

    task automatic send(input int v, input int gap);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data = 16'(v);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data = '0;
        repeat (gap - 1) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_an = 1'b0;
        @(negedge i_clk);
        i_rst_an = 1'b1;
    endtask

    task automatic check_seq(input string nm, input int exp[7]);
        check({nm, "_count"}, outq.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < outq.size()) check(nm, outq[i], exp[i]);
        end
    endtask

    initial begin
        int c0;
        i_rst_an = 1'b0;
        i_ena = 1'b1;
        i_valid = 1'b0;
        i_data = '0;
        repeat (3) @(negedge i_clk);
        check("reset_data", int'($signed(o_data)), 0);
        check("reset_busy", int'(o_busy), 0);
        i_rst_an = 1'b1;

        outq.delete();
        send(1000, 16);
        repeat (6) send(0, 16);
        check_seq("impulse", '{-23, 59, -137, 1203, -137, 59, -23});

        do_reset();
        outq.delete();
        send(32767, 16);
        repeat (6) send(0, 16);
        check_seq("pos_sat", '{-768, 1920, -4480, 32767, -4480, 1920, -768});

        do_reset();
        outq.delete();
        send(-32768, 16);
        repeat (6) send(0, 16);
        check_seq("neg_sat", '{768, -1920, 4480, -32768, 4480, -1920, 768});

        do_reset();
        outq.delete();
        repeat (10) send(1000, 10);
        check("dc_count", outq.size(), 10);
        if (outq.size() == 10) check("dc_value", outq[9], 1000);
        check("dc_overrun", int'(o_overrun), 0);

        do_reset();
        outq.delete();
        send(500, 4);
        send(777, 16);
        check("ovr_count", outq.size(), 1);
        if (outq.size() == 1) check("ovr_value", outq[0], -12);
        check("ovr_flag", int'(o_overrun), 1);
        do_reset();
        @(negedge i_clk);
        check("ovr_cleared", int'(o_overrun), 0);

        do_reset();
        outq.delete();
        vcyc.delete();
        @(negedge i_clk);
        c0 = cyc;
        i_valid = 1'b1;
        i_data = 16'd1000;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_ena = 1'b0;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        i_ena = 1'b1;
        repeat (16) @(negedge i_clk);
        check("frz_count", outq.size(), 1);
        if (vcyc.size() == 1) check("frz_cycle", vcyc[0], c0 + 14);
        if (outq.size() == 1) check("frz_value", outq[0], -23);
        check("frz_overrun", int'(o_overrun), 0);

        do_reset();
        outq.delete();
        send(1000, 3);
        do_reset();
        repeat (15) @(negedge i_clk);
        check("abort_count", outq.size(), 0);
        check("abort_data", int'($signed(o_data)), 0);
        send(2000, 16);
        check("abort_count2", outq.size(), 1);
        if (outq.size() == 1) check("abort_first", outq[0], -47);

        repeat (2) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filt_cic_comp.md
FILT_CIC_COMP -- requirements
Module: filt_cic_comp

Interface
REQ-001 SHALL have parameter gp_inp_width, default 16: signed input sample width; matches the CIC decimator output width.
REQ-002 SHALL have parameter gp_oup_width, default 16: signed output sample width.
REQ-003 SHALL have parameter gp_coef_width, default 12: signed coefficient width.
REQ-004 SHALL have parameter gp_coef_frac, default 10: coefficient fractional bits, so unity gain = 1024.
REQ-005 SHALL have parameters gp_c0/gp_c1/gp_c2/gp_c3, defaults -24/60/-140/1232: half of the symmetric 7-tap droop-compensation kernel h = [c0 c1 c2 c3 c2 c1 c0], sum 1024.
REQ-006 SHALL have port i_clk, input, 1: single clock, the fast CIC input-rate clock.
REQ-007 SHALL have port i_rst_an, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port i_ena, input, 1: global enable; low freezes all state.
REQ-009 SHALL have port i_valid, input, 1: one-cycle strobe marking a new decimated sample on i_data.
REQ-010 SHALL have port i_data, input, gp_inp_width: signed two's-complement sample from the CIC decimator.
REQ-011 SHALL have port o_data, output, gp_oup_width: signed compensated sample.
REQ-012 SHALL have port o_valid, output, 1: one-cycle strobe, o_data is new.
REQ-013 SHALL have port o_busy, output, 1: high whenever the FSM is not IDLE.
REQ-014 SHALL have port o_overrun, output, 1: sticky flag, an input sample was dropped.

Function
REQ-015 SHALL implement a serial single-multiplier MAC with FSM states IDLE, MAC, OUT.
REQ-016 In IDLE with i_ena=1 and i_valid=1, at the clock edge:
  - delay line x[0..6] SHALL shift, x[0] <= i_data;
  - accumulator SHALL clear and tap index SHALL be set to 0;
  - FSM SHALL go to MAC.
REQ-017 MAC SHALL last exactly 7 cycles: acc += h[k]*x[k] for k = 0..6; after k=6 the FSM SHALL go to OUT.
REQ-018 Accumulator width SHALL be gp_inp_width+gp_coef_width+3 (31 bits at defaults), full precision with no intermediate truncation.
REQ-019 OUT SHALL register o_data = saturate(floor((acc + 2^(gp_coef_frac-1)) / 2^gp_coef_frac)) to [-2^(gp_oup_width-1), 2^(gp_oup_width-1)-1], assert o_valid, and return to IDLE.
REQ-020 Rounding SHALL be round-half-up via an arithmetic shift; saturation SHALL clamp to the most-positive or most-negative value.
REQ-021 Latency: i_valid sampled at edge E0 -> o_valid high for exactly one cycle following edge E0+8; o_busy high for cycles E0+1 through E0+8.
REQ-022 o_data SHALL hold its value between o_valid strobes.
REQ-023 i_valid while o_busy=1 (including the OUT cycle) SHALL be ignored: delay line unchanged, o_overrun set to 1 and held until reset.
REQ-024 The upstream decimation factor SHALL be >= 9 for lossless operation; smaller factors produce overrun per REQ-023.
REQ-025 i_ena=0 SHALL freeze FSM, accumulator, tap index, delay line and outputs, except that o_valid SHALL be forced to 0.
REQ-026 i_valid with i_ena=0 SHALL be ignored and SHALL NOT set o_overrun.
REQ-027 Output sample n SHALL equal the rounded and saturated value of sum h[k]*x(n-k), with x(n) the n-th accepted input.

Reset
REQ-028 i_rst_an=0 SHALL asynchronously force FSM=IDLE, acc=0, tap index=0, x[0..6]=0, o_data=0, o_valid=0, o_busy=0, o_overrun=0.
REQ-029 Reset asserted mid-MAC SHALL abort the computation with no o_valid; the first accepted sample after release SHALL see an all-zero history.
REQ-030 After reset release, the first i_valid SHALL be acceptable on the first enabled edge.

Verification
REQ-031 Impulse: inputs 1000 then six 0, spaced 16 cycles apart -> o_data = -23, 59, -137, 1203, -137, 59, -23.
REQ-032 Positive saturation: single input 32767 followed by zeros -> 4th output = 32767 (unsaturated 39423); outputs 1-3 = -768, 1920, -4480.
REQ-033 Negative saturation: single input -32768 followed by zeros -> 4th output = -32768.
REQ-034 DC: constant 1000 for more than 7 samples -> steady-state output 1000; o_overrun stays 0.
REQ-035 Overrun: second i_valid 4 cycles after the first -> second sample dropped, o_overrun=1, one o_valid only; a later reset clears o_overrun.
REQ-036 Freeze and abort: i_ena low for 5 cycles mid-MAC -> o_valid delayed by exactly 5 cycles with unchanged value; i_rst_an pulsed mid-MAC -> no o_valid and all outputs 0.
